// File: rtl/echo_capture_pkg.sv
// Shared types and default widths for the echo_capture ADC capture stage.
package echo_capture_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DRAIN} echo_state_t;

  localparam int HALF_WIDTH    = 16;
  localparam int CNT_WIDTH_DEF = 16;
  localparam int OVF_WIDTH_DEF = 16;

endpackage

// File: rtl/echo_sample_packer.sv
// Packs kept samples two per 32-bit word, {second, first}; strobes when a word completes.
module echo_sample_packer
  import echo_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [2*HALF_WIDTH-1:0] word,
  output logic                    word_stb
);

  logic                  half_reg;
  logic [HALF_WIDTH-1:0] lo_reg;
  logic [HALF_WIDTH-1:0] sample_ext;

  assign sample_ext = HALF_WIDTH'(sample);

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      half_reg <= 1'b0;
      lo_reg   <= '0;
    end else if (sample_valid) begin
      if (!half_reg) lo_reg <= sample_ext;
      half_reg <= ~half_reg;
    end
  end

  // The second sample completes the word combinationally so the output
  // register can load it on the very next edge.
  assign word_stb = sample_valid & half_reg;
  assign word     = {sample_ext, lo_reg};

endmodule

// File: rtl/echo_capture.sv
// Triggered ADC capture: blanking delay, decimation, 2x16 packing, AXI-Stream output.
// Optional ramp test pattern enabled by defining ECHO_CAPTURE_TEST_PATTERN_EN.
module echo_capture
  import echo_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int OVF_WIDTH    = OVF_WIDTH_DEF
) (
  input  logic                    M_AXIS_ACLK,
  input  logic                    M_AXIS_ARESET,
  input  logic [SAMPLE_WIDTH-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic                    trig,
  input  logic [CNT_WIDTH-1:0]    cfg_delay,
  input  logic [CNT_WIDTH-1:0]    cfg_length,
  input  logic [7:0]              cfg_decim,
`ifdef ECHO_CAPTURE_TEST_PATTERN_EN
  input  logic                    cfg_test,
`endif
  output logic                    M_AXIS_TVALID,
  output logic [31:0]             M_AXIS_TDATA,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY,
  output logic                    busy,
  output logic [OVF_WIDTH-1:0]    overflow_cnt
);

  echo_state_t           state_reg, state_next;
  logic                  trig_q_reg;
  logic [CNT_WIDTH-1:0]  delay_cnt_reg, len_reg, word_cnt_reg, word_cnt_inc;
  logic [7:0]            decim_reg, decim_cnt_reg;
  logic                  tvalid_reg, tlast_reg;
  logic [31:0]           tdata_reg;
  logic [OVF_WIDTH-1:0]  ovf_reg;

  logic                  start, keep, accept, word_stb, word_last;
  logic [31:0]           word;
  logic [SAMPLE_WIDTH-1:0] sample_sel;

  assign start        = (state_reg == IDLE) && trig && !trig_q_reg && (cfg_length != '0);
  assign keep         = (state_reg == CAPTURE) && adc_valid && (decim_cnt_reg == 8'd0);
  assign accept       = tvalid_reg && M_AXIS_TREADY;
  assign word_cnt_inc = word_cnt_reg + CNT_WIDTH'(1);
  assign word_last    = word_stb && (word_cnt_inc == len_reg);

`ifdef ECHO_CAPTURE_TEST_PATTERN_EN
  logic                    test_reg;
  logic [SAMPLE_WIDTH-1:0] ramp_reg;

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      test_reg <= 1'b0;
      ramp_reg <= '0;
    end else if (start) begin
      test_reg <= cfg_test;
      ramp_reg <= '0;
    end else if (keep) begin
      ramp_reg <= ramp_reg + SAMPLE_WIDTH'(1);
    end
  end

  assign sample_sel = test_reg ? ramp_reg : adc_data;
`else
  assign sample_sel = adc_data;
`endif

  echo_sample_packer #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_packer (
    .clk          (M_AXIS_ACLK),
    .srst         (M_AXIS_ARESET),
    .clear        (start),
    .sample_valid (keep),
    .sample       (sample_sel),
    .word         (word),
    .word_stb     (word_stb)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (cfg_delay != '0) ? DELAY : CAPTURE;
      DELAY:   if (adc_valid && delay_cnt_reg == CNT_WIDTH'(1)) state_next = CAPTURE;
      CAPTURE: if (word_last) state_next = DRAIN;
      // A dropped final word still ends the capture once the held word leaves.
      DRAIN:   if (!tvalid_reg || accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_reg     <= IDLE;
      trig_q_reg    <= 1'b0;
      delay_cnt_reg <= '0;
      len_reg       <= '0;
      word_cnt_reg  <= '0;
      decim_reg     <= '0;
      decim_cnt_reg <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      tdata_reg     <= '0;
      ovf_reg       <= '0;
    end else begin
      state_reg  <= state_next;
      trig_q_reg <= trig;
      if (start) begin
        delay_cnt_reg <= cfg_delay;
        len_reg       <= cfg_length;
        decim_reg     <= cfg_decim;
        word_cnt_reg  <= '0;
        decim_cnt_reg <= '0;
      end else begin
        if (state_reg == DELAY && adc_valid)
          delay_cnt_reg <= delay_cnt_reg - CNT_WIDTH'(1);
        if (state_reg == CAPTURE && adc_valid)
          decim_cnt_reg <= (decim_cnt_reg == decim_reg) ? 8'd0 : decim_cnt_reg + 8'd1;
        if (word_stb)
          word_cnt_reg <= word_cnt_inc;
      end

      // Single-entry output register; a word arriving against a stalled one is lost.
      if (word_stb) begin
        if (tvalid_reg && !M_AXIS_TREADY) begin
          if (ovf_reg != '1) ovf_reg <= ovf_reg + OVF_WIDTH'(1);
        end else begin
          tvalid_reg <= 1'b1;
          tdata_reg  <= word;
          tlast_reg  <= word_last;
        end
      end else if (accept) begin
        tvalid_reg <= 1'b0;
        tlast_reg  <= 1'b0;
      end
    end
  end

  assign M_AXIS_TVALID = tvalid_reg;
  assign M_AXIS_TDATA  = tdata_reg;
  assign M_AXIS_TLAST  = tlast_reg;
  assign busy          = (state_reg != IDLE);
  assign overflow_cnt  = ovf_reg;

endmodule

// File: tb/tb_echo_capture.sv
// Scoreboard bench for echo_capture: directed captures, monitor pops expected words on handshake.
module tb_echo_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] cfg_delay = '0;
  logic [15:0] cfg_length = '0;
  logic [7:0]  cfg_decim = '0;
  logic        tready = 1'b1;
  logic        tvalid, tlast, busy;
  logic [31:0] tdata;
  logic [15:0] ovf;
`ifdef ECHO_CAPTURE_TEST_PATTERN_EN
  logic        cfg_test = 1'b0;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  echo_capture dut (
    .M_AXIS_ACLK   (clk),
    .M_AXIS_ARESET (rst),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .trig          (trig),
    .cfg_delay     (cfg_delay),
    .cfg_length    (cfg_length),
    .cfg_decim     (cfg_decim),
`ifdef ECHO_CAPTURE_TEST_PATTERN_EN
    .cfg_test      (cfg_test),
`endif
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TREADY (tready),
    .busy          (busy),
    .overflow_cnt  (ovf)
  );

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_word: got tdata=0x%08h tlast=%0b, expected none", tdata, tlast);
      end else begin
        check("stream_word", {tlast, tdata}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
  endtask

  task automatic send(input logic [15:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(name, {32'd0, busy}, 33'd0);
  endtask

  task automatic cfg(input logic [15:0] d, input logic [15:0] l, input logic [7:0] dc);
    cfg_delay  = d;
    cfg_length = l;
    cfg_decim  = dc;
  endtask

  initial begin
    repeat (3) tick();
    check("reset_tvalid", {32'd0, tvalid}, 33'd0);
    check("reset_tlast", {32'd0, tlast}, 33'd0);
    check("reset_tdata", {1'b0, tdata}, 33'd0);
    check("reset_busy", {32'd0, busy}, 33'd0);
    check("reset_ovf", {17'd0, ovf}, 33'd0);
    rst = 1'b0;
    tick();

    // Basic capture.
    cfg(16'd0, 16'd3, 8'd0);
    exp_q.push_back({1'b0, 32'h0002_0001});
    exp_q.push_back({1'b0, 32'h0004_0003});
    exp_q.push_back({1'b1, 32'h0006_0005});
    pulse_trig();
    for (int i = 1; i <= 6; i++) send(16'(i));
    check("basic_busy_before_accept", {32'd0, busy}, 33'd1);
    tick();
    check("basic_busy_after_accept", {32'd0, busy}, 33'd0);
    check("basic_ovf", {17'd0, ovf}, 33'd0);
    check("basic_q_empty", 33'(exp_q.size()), 33'd0);

    // Blanking delay plus decimation.
    cfg(16'd4, 16'd1, 8'd2);
    exp_q.push_back({1'b1, 32'h0007_0004});
    pulse_trig();
    for (int i = 0; i <= 20; i++) send(16'(i));
    wait_idle("decim_idle");
    check("decim_q_empty", 33'(exp_q.size()), 33'd0);

    // Back-pressure: first word held, the other three dropped.
    cfg(16'd0, 16'd4, 8'd0);
    tready = 1'b0;
    pulse_trig();
    for (int i = 1; i <= 8; i++) send(16'(i));
    tick();
    check("bp_tvalid", {32'd0, tvalid}, 33'd1);
    check("bp_tdata", {1'b0, tdata}, {1'b0, 32'h0002_0001});
    check("bp_tlast", {32'd0, tlast}, 33'd0);
    check("bp_ovf", {17'd0, ovf}, 33'd3);
    check("bp_busy_held", {32'd0, busy}, 33'd1);
    exp_q.push_back({1'b0, 32'h0002_0001});
    tready = 1'b1;
    tick();
    check("bp_busy_released", {32'd0, busy}, 33'd0);
    check("bp_q_empty", 33'(exp_q.size()), 33'd0);

    // Trigger filtering and config latching.
    cfg(16'd0, 16'd2, 8'd0);
    exp_q.push_back({1'b0, 32'h0002_0001});
    exp_q.push_back({1'b1, 32'h0004_0003});
    pulse_trig();
    cfg_length = 16'd5;
    send(16'd1);
    send(16'd2);
    pulse_trig();
    send(16'd3);
    send(16'd4);
    wait_idle("filter_idle");
    cfg_length = 16'd0;
    pulse_trig();
    check("zero_len_ignored", {32'd0, busy}, 33'd0);
    cfg_length = 16'd2;
    for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i));
    tick();
    check("filter_q_empty", 33'(exp_q.size()), 33'd0);

    // Reset mid-capture with a stalled word and a half-packed word.
    cfg(16'd0, 16'd2, 8'd0);
    tready = 1'b0;
    pulse_trig();
    send(16'h000A);
    send(16'h000B);
    send(16'h000C);
    rst = 1'b1;
    tick();
    check("midrst_tvalid", {32'd0, tvalid}, 33'd0);
    check("midrst_busy", {32'd0, busy}, 33'd0);
    check("midrst_ovf", {17'd0, ovf}, 33'd0);
    rst = 1'b0;
    tready = 1'b1;
    tick();
    cfg(16'd0, 16'd1, 8'd0);
    exp_q.push_back({1'b1, 32'h0022_0021});
    pulse_trig();
    send(16'h0021);
    send(16'h0022);
    wait_idle("midrst_idle");
    check("midrst_q_empty", 33'(exp_q.size()), 33'd0);

`ifdef ECHO_CAPTURE_TEST_PATTERN_EN
    // Ramp test pattern replaces ADC data.
    cfg(16'd0, 16'd2, 8'd0);
    cfg_test = 1'b1;
    exp_q.push_back({1'b0, 32'h0001_0000});
    exp_q.push_back({1'b1, 32'h0003_0002});
    pulse_trig();
    for (int i = 0; i < 4; i++) send(16'h5A5A ^ 16'(i * 7));
    wait_idle("ramp_idle");
    check("ramp_q_empty", 33'(exp_q.size()), 33'd0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
